mef_select_produto: RTL and testbench

Parametrised successor to the two-product selection FSM in the production controller. Selects one of NUM_PROD products, runs a NUM_STEPS step sequence driven by step pulses, then waits for acknowledge before returning to the menu. Adds cancel/abort from any active state and an optional step watchdog. Sits between the front-panel input debouncers and the display/actuator decoders.

---
 rtl/mef_pkg.sv | 20 ++
 rtl/mef_select_produto_if.sv | 34 +++
 rtl/mef_watchdog.sv | 41 ++++
 rtl/mef_select_produto.sv | 154 +++++++++++++++
 tb/tb_mef_select_produto.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mef_pkg.sv
// Shared definitions for the product-selection FSM: state codes and widths.
package mef_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] MENU  = 3'd0;
    localparam logic [STATE_W-1:0] ARMED = 3'd1;
    localparam logic [STATE_W-1:0] RUN   = 3'd2;
    localparam logic [STATE_W-1:0] DONE  = 3'd3;
    localparam logic [STATE_W-1:0] FAULT = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_MENU  = MENU,
        S_ARMED = ARMED,
        S_RUN   = RUN,
        S_DONE  = DONE,
        S_FAULT = FAULT
    } state_e;

endpackage

// File: rtl/mef_select_produto_if.sv
// Front-panel command inputs and registered status outputs of mef_select_produto.
interface mef_select_produto_if #(
    parameter int NUM_PROD  = 2,
    parameter int NUM_STEPS = 4
);
    import mef_pkg::*;

    localparam int PROD_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam int STEP_W = $clog2(NUM_STEPS + 1);

    logic [PROD_W-1:0]  sel;
    logic               go;
    logic               start;
    logic               step;
    logic               cancel;
    logic               ack;
    logic [STATE_W-1:0] state_o;
    logic [PROD_W-1:0]  prod_o;
    logic [STEP_W-1:0]  step_o;
    logic               busy;
    logic               done;
    logic               abort;

    modport master (
        output sel, go, start, step, cancel, ack,
        input  state_o, prod_o, step_o, busy, done, abort
    );

    modport slave (
        input  sel, go, start, step, cancel, ack,
        output state_o, prod_o, step_o, busy, done, abort
    );

endinterface

// File: rtl/mef_watchdog.sv
// Step watchdog: counts idle cycles while enabled, flags expiry at TIMEOUT_CYC.
module mef_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter saturates at LIMIT; the cycle spent at LIMIT is the TIMEOUT_CYC-th idle cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/mef_select_produto.sv
// Product selection / step sequencing FSM. Optional step watchdog and FAULT
// state are enabled by defining MEF_TIMEOUT_EN.
module mef_select_produto
    import mef_pkg::*;
#(
    parameter int NUM_PROD    = 2,
    parameter int NUM_STEPS   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    mef_select_produto_if.slave  bus
);

    localparam int PROD_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam int STEP_W = $clog2(NUM_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [PROD_W:0]   PROD_LIM  = (PROD_W + 1)'(NUM_PROD);

    if ((NUM_PROD < 2) || (NUM_STEPS < 1) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("mef_select_produto: invalid parameter set");
    end

    state_e            state_q, state_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              abort_q, abort_d;
    logic              busy_q;
    logic              done_q;
    logic              sel_valid_s;

    assign sel_valid_s = ({1'b0, bus.sel} < PROD_LIM);

`ifdef MEF_TIMEOUT_EN
    logic wd_expired_s;
    logic wd_clear_s;
    logic wd_enable_s;

    // Restart on RUN entry (counter held clear outside RUN) and on every step.
    assign wd_enable_s = (state_q == S_RUN);
    assign wd_clear_s  = (state_q != S_RUN) || bus.step;

    mef_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );
`endif

    // Next-state, product latch and step counter logic.
    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        step_d  = step_q;
        abort_d = 1'b0;
        case (state_q)
            S_MENU: begin
                if (bus.go && sel_valid_s) begin
                    state_d = S_ARMED;
                    prod_d  = bus.sel;
                end else begin
                    state_d = S_MENU;
                end
            end
            S_ARMED: begin
                if (bus.cancel) begin
                    state_d = S_MENU;
                    abort_d = 1'b1;
                end else if (bus.start) begin
                    state_d = S_RUN;
                    step_d  = '0;
                end else if (bus.go && sel_valid_s) begin
                    prod_d  = bus.sel;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_RUN: begin
                if (bus.cancel) begin
                    state_d = S_MENU;
                    abort_d = 1'b1;
                    step_d  = '0;
                end else if (bus.step) begin
                    step_d = step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
`ifdef MEF_TIMEOUT_EN
                end else if (wd_expired_s) begin
                    state_d = S_FAULT;
                    abort_d = 1'b1;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // cancel is a plain acknowledge here: the run already finished.
                if (bus.ack || bus.cancel) begin
                    state_d = S_MENU;
                    step_d  = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
`ifdef MEF_TIMEOUT_EN
            S_FAULT: begin
                if (bus.ack || bus.cancel) begin
                    state_d = S_MENU;
                    step_d  = '0;
                end else begin
                    state_d = S_FAULT;
                end
            end
`endif
            default: begin
                state_d = S_MENU;
            end
        endcase
    end

    // State and output registers; busy/done follow the registered state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_MENU;
            prod_q  <= '0;
            step_q  <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            step_q  <= step_d;
            abort_q <= abort_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.state_o = state_q;
    assign bus.prod_o  = prod_q;
    assign bus.step_o  = step_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.abort   = abort_q;

endmodule

// File: tb/tb_mef_select_produto.sv
// Directed table-driven bench for mef_select_produto (NUM_PROD=5 so that
// out-of-range selector codes are representable, NUM_STEPS=4, TIMEOUT_CYC=16).
module tb_mef_select_produto;

    localparam int NUM_PROD    = 5;
    localparam int NUM_STEPS   = 4;
    localparam int TIMEOUT_CYC = 16;

    logic clk;
    logic rst;

    mef_select_produto_if #(.NUM_PROD(NUM_PROD), .NUM_STEPS(NUM_STEPS)) bus ();

    mef_select_produto #(
        .NUM_PROD    (NUM_PROD),
        .NUM_STEPS   (NUM_STEPS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] sel;
        logic       go;
        logic       start;
        logic       step;
        logic       cancel;
        logic       ack;
        int         e_state;
        int         e_prod;
        int         e_step;
        int         e_abort;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic void add(logic r, logic [2:0] s, logic g, logic st, logic sp,
                                logic c, logic a, int es, int ep, int estp, int eab);
        vec_t v;
        v.rst_n = r; v.sel = s; v.go = g; v.start = st; v.step = sp;
        v.cancel = c; v.ack = a;
        v.e_state = es; v.e_prod = ep; v.e_step = estp; v.e_abort = eab;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [2:0] s, logic g, logic st, logic sp, logic c, logic a);
        rst = r; bus.sel = s; bus.go = g; bus.start = st;
        bus.step = sp; bus.cancel = c; bus.ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, int es, int ep, int estp, int eab);
        chk({tag, " state"}, int'(bus.state_o), es);
        chk({tag, " prod"},  int'(bus.prod_o),  ep);
        chk({tag, " step"},  int'(bus.step_o),  estp);
        chk({tag, " busy"},  int'(bus.busy),    (es == 2) ? 1 : 0);
        chk({tag, " done"},  int'(bus.done),    (es == 3) ? 1 : 0);
        chk({tag, " abort"}, int'(bus.abort),   eab);
    endtask

    initial begin
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   rst  sel   go    start step  cancel ack    state prod step abort
        add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0); // reset
        add(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0); // invalid sel
        add(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0); // start in MENU
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0, 0, 0); // step in MENU
        add(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 3, 0, 0);
        add(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 0, 0); // reselect
        add(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 0, 0); // invalid reselect
        add(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  0, 1, 0, 1); // cancel beats start
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 1, 0, 0);
        add(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 2, 0, 0);
        add(1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  2, 2, 0, 0); // start beats go
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 2, 1, 0);
        add(1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  2, 2, 2, 0); // go/start/ack ignored
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  2, 2, 2, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 2, 3, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  3, 2, 4, 0); // last step -> DONE
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  3, 2, 4, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  0, 2, 0, 0); // ack
        add(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 0, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  2, 0, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 0, 1, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 0, 2, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  0, 0, 0, 1); // cancel beats step
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0);
        add(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 4, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  2, 4, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 4, 1, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 4, 2, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 4, 3, 0);
        add(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0, 0, 0); // reset mid-run
        add(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  2, 1, 0, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 1, 1, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 1, 2, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  2, 1, 3, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  3, 1, 4, 0);
        add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, 1, 0, 0); // cancel in DONE: no abort

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].sel, vecs[i].go, vecs[i].start,
                  vecs[i].step, vecs[i].cancel, vecs[i].ack);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_prod,
                    vecs[i].e_step, vecs[i].e_abort);
        end

        // Enter RUN with one step done, then go quiet.
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk_all("seq_run_entry", 2, 2, 1, 0);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MEF_TIMEOUT_EN
        for (int c = 1; c < TIMEOUT_CYC; c++) begin
            tick();
            chk_all($sformatf("wd_idle%0d", c), 2, 2, 1, 0);
        end
        tick();
        chk_all("wd_fault", 4, 2, 1, 1);
        drive(1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        chk_all("wd_fault_hold", 4, 2, 1, 0);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        chk_all("wd_fault_ack", 0, 2, 0, 0);
`else
        for (int c = 1; c <= 100; c++) begin
            tick();
            if ((c % 20) == 0) begin
                chk_all($sformatf("idle%0d", c), 2, 2, 1, 0);
            end
        end
        // Back-to-back step pulses each count.
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk_all("b2b_2", 2, 2, 2, 0);
        tick();
        chk_all("b2b_3", 2, 2, 3, 0);
        tick();
        chk_all("b2b_done", 3, 2, 4, 0);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        chk_all("b2b_ack", 0, 2, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
